// File: rtl/password_entry.sv
// Keypad front end for the lock controller: debounces four active-low keys and
// runs the digit entry FSM that feeds the 7-segment display and the mode controller.
module password_entry #(
  parameter int DIGITS          = 6,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit MASK            = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  restart_i,
  input  logic [3:0]            switches_i,
  input  logic [3:0]            buttons_i,
  output logic [6:0]            seg_o,
  output logic [2:0]            pos_o,
  output logic                  seg_valid_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   code_o,
  output logic [3:0]            len_o,
  output logic                  err_o
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     LEN_MAX  = 4'(DIGITS);
  localparam logic [2:0]     POS_LAST = 3'(DIGITS - 1);
  localparam logic [6:0]     SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {ENTRY, WIPE, SUBMIT, HOLD} state_t;

  // Patterns are written a..g left to right; seg_o[0] carries segment a.
  function automatic logic [6:0] to_port(input logic [6:0] abcdefg);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = abcdefg[6-i];
    return r;
  endfunction

  function automatic logic [6:0] numeral(input logic [3:0] d);
    case (d)
      4'd0:    return to_port(7'b0000001);
      4'd1:    return to_port(7'b1001111);
      4'd2:    return to_port(7'b0010010);
      4'd3:    return to_port(7'b0000110);
      4'd4:    return to_port(7'b1001100);
      4'd5:    return to_port(7'b0100100);
      4'd6:    return to_port(7'b0100000);
      4'd7:    return to_port(7'b0001111);
      4'd8:    return to_port(7'b0000000);
      4'd9:    return to_port(7'b0000100);
      default: return SEG_BLANK;
    endcase
  endfunction

  logic [3:0] sync1_q, sync2_q, press;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= buttons_i;
      sync2_q <= sync1_q;
    end
  end

  // The press pulse fires on the same cycle the accepted level rises.
  for (genvar k = 0; k < 4; k++) begin : g_key
    logic          smp;
    logic          lvl_q;
    logic [CW-1:0] cnt_q;

    assign smp      = ~sync2_q[k];
    assign press[k] = smp && !lvl_q && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else if (smp == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        lvl_q <= smp;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  logic act_clr, act_sub, act_bsp, act_ent;
  assign act_clr = press[3];
  assign act_sub = press[2] & ~press[3];
  assign act_bsp = press[1] & ~|press[3:2];
  assign act_ent = press[0] & ~|press[3:1];

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] buf_q, buf_d;
  logic [3:0]          len_q, len_d;
  logic [2:0]          wpos_q, wpos_d, pos_q, pos_d;
  logic [6:0]          seg_q, seg_d;
  logic                segv_q, segv_d, done_q, done_d, err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ENTRY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (restart_i) begin
      state_d = WIPE;
    end else begin
      case (state_q)
        ENTRY:   if (act_clr) state_d = WIPE;
                 else if (act_sub && len_q != 4'd0) state_d = SUBMIT;
        WIPE:    if (wpos_q == POS_LAST) state_d = ENTRY;
        SUBMIT:  state_d = HOLD;
        HOLD:    state_d = HOLD;
        default: state_d = ENTRY;
      endcase
    end
  end

  always_comb begin
    buf_d  = buf_q;
    len_d  = len_q;
    wpos_d = wpos_q;
    seg_d  = seg_q;
    pos_d  = pos_q;
    segv_d = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (restart_i) begin
      buf_d  = '0;
      len_d  = 4'd0;
      wpos_d = 3'd0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (act_clr) begin
            buf_d  = '0;
            len_d  = 4'd0;
            wpos_d = 3'd0;
          end else if (act_sub) begin
            err_d = (len_q == 4'd0);
          end else if (act_bsp) begin
            if (len_q == 4'd0) begin
              err_d = 1'b1;
            end else begin
              len_d = len_q - 4'd1;
              for (int i = 0; i < DIGITS; i++)
                if (i == int'(len_d)) buf_d[4*i +: 4] = 4'h0;
              seg_d  = SEG_BLANK;
              pos_d  = len_d[2:0];
              segv_d = 1'b1;
            end
          end else if (act_ent) begin
            if (switches_i > 4'd9 || len_q == LEN_MAX) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < DIGITS; i++)
                if (i == int'(len_q)) buf_d[4*i +: 4] = switches_i;
              seg_d  = MASK ? to_port(7'b1111110) : numeral(switches_i);
              pos_d  = len_q[2:0];
              segv_d = 1'b1;
              len_d  = len_q + 4'd1;
            end
          end
        end
        WIPE: begin
          seg_d  = SEG_BLANK;
          pos_d  = wpos_q;
          segv_d = 1'b1;
          wpos_d = wpos_q + 3'd1;
        end
        SUBMIT:  done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      len_q  <= 4'd0;
      wpos_q <= 3'd0;
      seg_q  <= SEG_BLANK;
      pos_q  <= 3'd0;
      segv_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      len_q  <= len_d;
      wpos_q <= wpos_d;
      seg_q  <= seg_d;
      pos_q  <= pos_d;
      segv_q <= segv_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign seg_o       = seg_q;
  assign pos_o       = pos_q;
  assign seg_valid_o = segv_q;
  assign done_o      = done_q;
  assign code_o      = buf_q;
  assign len_o       = len_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_password_entry.sv
// Scoreboard bench for password_entry: stimulus queues expected strobes,
// a negedge monitor pops and compares each one the DUT emits.
module tb_password_entry;
  localparam int DIGITS = 6;
  localparam int DB     = 4;
  localparam int K_SEG = 0, K_ERR = 1, K_DONE = 2;
  localparam logic [6:0] BLANK = 7'h7F;

  logic        clk = 1'b0, rst_n = 1'b0, restart = 1'b0;
  logic [3:0]  sw = 4'd0, btn = 4'hF;
  logic [6:0]  seg;
  logic [2:0]  pos;
  logic        seg_valid, done, err;
  logic [23:0] code;
  logic [3:0]  len;

  password_entry #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DB), .MASK(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .restart_i(restart), .switches_i(sw), .buttons_i(btn),
    .seg_o(seg), .pos_o(pos), .seg_valid_o(seg_valid), .done_o(done),
    .code_o(code), .len_o(len), .err_o(err));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int ntests = 0, nfail = 0, last_strobe_cyc = 0;

  typedef struct {int kind; logic [2:0] pos; logic [6:0] seg; logic [23:0] code; logic [3:0] len;} exp_t;
  exp_t q[$];

  function automatic logic [6:0] port_order(input logic [6:0] s);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = s[6-i];
    return r;
  endfunction

  function automatic logic [6:0] numeral(input int d);
    logic [6:0] t [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return port_order(t[d]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_seg(input logic [2:0] p, input logic [6:0] s);
    exp_t e; e.kind = K_SEG; e.pos = p; e.seg = s; e.code = '0; e.len = '0; q.push_back(e);
  endtask
  task automatic exp_err();
    exp_t e; e.kind = K_ERR; e.pos = '0; e.seg = '0; e.code = '0; e.len = '0; q.push_back(e);
  endtask
  task automatic exp_done(input logic [23:0] c, input logic [3:0] l);
    exp_t e; e.kind = K_DONE; e.pos = '0; e.seg = '0; e.code = c; e.len = l; q.push_back(e);
  endtask
  task automatic exp_wipe();
    for (int i = 0; i < DIGITS; i++) exp_seg(3'(i), BLANK);
  endtask

  always @(negedge clk) begin
    if (rst_n && (seg_valid || done || err)) begin
      last_strobe_cyc = cyc;
      if (q.size() == 0) begin
        ntests++; nfail++;
        $display("FAIL unexpected_strobe: seg_valid=%b done=%b err=%b pos=%0d, expected no strobe",
                 seg_valid, done, err, pos);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", {seg_valid, done, err},
            (e.kind == K_SEG) ? 3'b100 : (e.kind == K_DONE) ? 3'b010 : 3'b001);
        if (e.kind == K_SEG) begin
          chk("strobe_pos", pos, e.pos);
          chk("strobe_seg", seg, e.seg);
        end else if (e.kind == K_DONE) begin
          chk("done_code", code, e.code);
          chk("done_len", len, e.len);
        end
      end
    end
  end

  task automatic press(input logic [3:0] keys, input logic [3:0] s, output int st);
    @(posedge clk); #1;
    sw  = s;
    btn = ~keys;
    st  = cyc;
    repeat (DB + 8) @(posedge clk);
    #1 btn = 4'hF;
    repeat (DB + 8) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    bit found;
    #1000000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bit found;
    // 1. reset and digit entry
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg, BLANK);
    chk("rst_pos", pos, 0);
    chk("rst_strobes", {seg_valid, done, err}, 0);
    chk("rst_len", len, 0);
    chk("rst_code", code, 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    exp_seg(0, numeral(3)); press(4'b0001, 4'd3, st);
    chk("latency_d3", last_strobe_cyc - st, DB + 2);
    exp_seg(1, numeral(7)); press(4'b0001, 4'd7, st);
    chk("latency_d7", last_strobe_cyc - st, DB + 2);
    chk("len_after_2", len, 2);

    // 2. bounce rejection
    sw = 4'd5;
    exp_seg(2, numeral(5));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 btn[0] = ~btn[0];
      @(posedge clk);
    end
    press(4'b0001, 4'd5, st);
    chk("len_after_bounce", len, 3);
    chk("code_after_bounce", code, 24'h000573);

    // 3. boundary errors
    exp_wipe(); press(4'b1000, 4'd0, st);
    chk("len_after_clear", len, 0);
    exp_err(); press(4'b0010, 4'd0, st);
    exp_err(); press(4'b0001, 4'd12, st);
    chk("len_after_errs", len, 0);
    for (int d = 1; d <= 6; d++) begin
      exp_seg(3'(d - 1), numeral(d)); press(4'b0001, 4'(d), st);
    end
    exp_err(); press(4'b0001, 4'd7, st);
    chk("len_full", len, 6);
    chk("code_full", code, 24'h654321);
    exp_seg(5, BLANK); press(4'b0010, 4'd0, st);
    chk("len_after_bsp", len, 5);
    chk("code_after_bsp", code, 24'h054321);

    // 4. submit, hold, restart
    exp_wipe(); press(4'b1000, 4'd0, st);
    exp_seg(0, numeral(4)); press(4'b0001, 4'd4, st);
    exp_seg(1, numeral(2)); press(4'b0001, 4'd2, st);
    exp_seg(2, numeral(9)); press(4'b0001, 4'd9, st);
    exp_done(24'h000924, 3); press(4'b0100, 4'd0, st);
    press(4'b0001, 4'd5, st);
    press(4'b0010, 4'd0, st);
    press(4'b1000, 4'd0, st);
    chk("hold_len", len, 3);
    chk("hold_code", code, 24'h000924);
    exp_wipe();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    repeat (DIGITS + 6) @(posedge clk);
    #1;
    chk("restart_len", len, 0);
    chk("restart_code", code, 0);

    // 5. clear beats enter in the same cycle
    exp_seg(0, numeral(1)); press(4'b0001, 4'd1, st);
    exp_seg(1, numeral(8)); press(4'b0001, 4'd8, st);
    exp_wipe(); press(4'b1001, 4'd6, st);
    chk("prio_len", len, 0);
    chk("prio_code", code, 0);

    // 6. async reset in the middle of a wipe
    for (int i = 0; i < 4; i++) exp_seg(3'(i), BLANK);
    @(posedge clk); #1 btn = 4'b0111;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (seg_valid && pos == 3'd3) found = 1'b1;
    end
    chk("wipe_pos3_seen", found, 1);
    #1 rst_n = 1'b0;
    btn = 4'hF;
    #1;
    chk("arst_seg", seg, BLANK);
    chk("arst_seg_valid", seg_valid, 0);
    chk("arst_len", len, 0);
    chk("arst_pos", pos, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_strobe_after_arst", q.size(), 0);
    exp_seg(0, numeral(0)); press(4'b0001, 4'd0, st);
    chk("len_after_arst_entry", len, 1);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
